// File: rtl/branch_predictor_pkg.sv
// Shared widths, counter type and in-flight record layout for the gshare
// direction predictor.
package branch_predictor_pkg;

    localparam int PATTERN_WIDTH  = 8;
    localparam int INST_MEM_WIDTH = 14;
    localparam int N_INFLIGHT     = 4;
    localparam int TABLE_DEPTH    = 1 << PATTERN_WIDTH;

    typedef logic [1:0] counter_t;

    localparam counter_t COUNTER_INIT = 2'b01;

    // One record per uncommitted predicted branch: the guess and the counter it came from.
    typedef struct packed {
        logic                     pred;
        logic [PATTERN_WIDTH-1:0] idx;
    } inflight_t;

endpackage

// File: rtl/sat_counter2.sv
// Next value of a 2-bit saturating counter: count up on taken, down on
// not-taken, holding at 3 and 0.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  counter_t value,
    input  logic     taken,
    output counter_t next_value
);

    always_comb begin
        next_value = value;
        if (taken) begin
            if (value != 2'b11) next_value = value + 2'd1;
        end else begin
            if (value != 2'b00) next_value = value - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// gshare predictor: combinational lookup at issue, counter training and
// speculative-history repair at commit.
module branch_predictor
    import branch_predictor_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lookup_valid,
    output logic                      lookup_ready,
    input  logic [INST_MEM_WIDTH-1:0] lookup_pc,
    input  logic [INST_MEM_WIDTH-1:0] lookup_target,
    output logic                      prediction,
    output logic [PATTERN_WIDTH-1:0]  pattern,
    output logic [INST_MEM_WIDTH-1:0] addr_on_failure,
    output logic [INST_MEM_WIDTH-1:0] predicted_pc,
    input  logic                      commit_valid,
    input  logic                      commit_failure,
    input  logic [PATTERN_WIDTH-1:0]  commit_pattern
);

    localparam int PTR_W = $clog2(N_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;

    logic [PATTERN_WIDTH-1:0]  history;
    counter_t                  ctr_table [TABLE_DEPTH];
    inflight_t                 fifo [N_INFLIGHT];
    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;
    logic [CNT_W-1:0]          count;

    logic [PATTERN_WIDTH-1:0]  idx;
    logic [INST_MEM_WIDTH-1:0] pc1;
    inflight_t                 head_entry;
    logic                      taken;
    logic                      flush;
    logic                      do_pop;
    logic                      accept;
    counter_t                  ctr_next;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_INFLIGHT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Lookup side: a lookup transfers on a cycle where lookup_valid and
    // lookup_ready are both high; ready may depend on commit_valid so a full
    // queue can still accept when its head is retiring in the same cycle.
    assign idx             = lookup_pc[PATTERN_WIDTH-1:0] ^ history;
    assign prediction      = ctr_table[idx][1];
    assign pattern         = history;
    assign pc1             = lookup_pc + INST_MEM_WIDTH'(1);
    assign predicted_pc    = prediction ? lookup_target : pc1;
    assign addr_on_failure = prediction ? pc1 : lookup_target;
    assign lookup_ready    = (count < CNT_W'(N_INFLIGHT)) || commit_valid;

    assign head_entry = fifo[head];
    assign taken      = head_entry.pred ^ commit_failure;
    assign flush      = commit_valid && commit_failure;
    assign do_pop     = commit_valid && (count != '0);
    // A lookup in a flush cycle is on the wrong path and is dropped.
    assign accept     = lookup_valid && lookup_ready && !flush;

    sat_counter2 u_sat_counter2 (
        .value      (ctr_table[head_entry.idx]),
        .taken      (taken),
        .next_value (ctr_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            history <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                ctr_table[i] <= COUNTER_INIT;
            end
        end else begin
            if (do_pop) begin
                ctr_table[head_entry.idx] <= ctr_next;
                head                      <= next_ptr(head);
            end
            if (flush && do_pop) begin
                // Rebuild history as it was before the branch, plus its real outcome.
                history <= {commit_pattern[PATTERN_WIDTH-2:0], taken};
                count   <= '0;
                tail    <= next_ptr(head);
            end else begin
                if (accept) begin
                    tail    <= next_ptr(tail);
                    history <= {history[PATTERN_WIDTH-2:0], prediction};
                end
                count <= count + CNT_W'(accept) - CNT_W'(do_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            fifo[tail] <= '{pred: prediction, idx: idx};
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: table of reset-state lookups plus
// hand-traced training, flush, full-queue, wrap and mid-stream reset sequences.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic                      clk;
    logic                      reset;
    logic                      lookup_valid;
    logic                      lookup_ready;
    logic [INST_MEM_WIDTH-1:0] lookup_pc;
    logic [INST_MEM_WIDTH-1:0] lookup_target;
    logic                      prediction;
    logic [PATTERN_WIDTH-1:0]  pattern;
    logic [INST_MEM_WIDTH-1:0] addr_on_failure;
    logic [INST_MEM_WIDTH-1:0] predicted_pc;
    logic                      commit_valid;
    logic                      commit_failure;
    logic [PATTERN_WIDTH-1:0]  commit_pattern;

    int tests;
    int fails;
    logic [INST_MEM_WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [13:0] pc;
        logic [13:0] tgt;
        logic        pred;
        logic [13:0] ppc;
        logic [13:0] aof;
    } lookup_vec_t;

    typedef struct {
        logic [13:0] pc;
        logic [7:0]  pat;
        logic        pred;
        logic        fail;
        logic [7:0]  cpat;
        logic [1:0]  ctr;
        logic [7:0]  hist;
    } train_vec_t;

    lookup_vec_t lvec [5];
    train_vec_t  tvec [8];

    branch_predictor dut (
        .clk             (clk),
        .reset           (reset),
        .lookup_valid    (lookup_valid),
        .lookup_ready    (lookup_ready),
        .lookup_pc       (lookup_pc),
        .lookup_target   (lookup_target),
        .prediction      (prediction),
        .pattern         (pattern),
        .addr_on_failure (addr_on_failure),
        .predicted_pc    (predicted_pc),
        .commit_valid    (commit_valid),
        .commit_failure  (commit_failure),
        .commit_pattern  (commit_pattern)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Stimulus must never commit into an empty queue.
    always @(posedge clk) begin
        if (!reset && commit_valid && dut.count == '0) begin
            fails++;
            $display("FAIL illegal_commit: commit_valid with count=0 at %0t", $time);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs settle by +1.
    task automatic cycle(input logic lv, input logic [13:0] pc, input logic [13:0] tgt,
                         input logic cv, input logic cf, input logic [7:0] cp);
        @(negedge clk);
        lookup_valid   = lv;
        lookup_pc      = pc;
        lookup_target  = tgt;
        commit_valid   = cv;
        commit_failure = cf;
        commit_pattern = cp;
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 14'h0, 14'h0, 1'b0, 1'b0, 8'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        lookup_valid = 1'b0; lookup_pc = '0; lookup_target = '0;
        commit_valid = 1'b0; commit_failure = 1'b0; commit_pattern = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int bad;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        lookup_valid = 1'b0; lookup_pc = '0; lookup_target = '0;
        commit_valid = 1'b0; commit_failure = 1'b0; commit_pattern = '0;

        lvec[0] = '{14'h0010, 14'h0100, 1'b0, 14'h0011, 14'h0100};
        lvec[1] = '{14'h0000, 14'h3FFF, 1'b0, 14'h0001, 14'h3FFF};
        lvec[2] = '{14'h3FFF, 14'h1234, 1'b0, 14'h0000, 14'h1234};
        lvec[3] = '{14'h2ABC, 14'h0055, 1'b0, 14'h2ABD, 14'h0055};
        lvec[4] = '{14'h00FF, 14'h0000, 1'b0, 14'h0100, 14'h0000};

        // Taken x4 then not-taken x4 at idx 0x10; pc = 0x10 ^ history each round.
        tvec[0] = '{14'h010, 8'h00, 1'b0, 1'b1, 8'h00, 2'd2, 8'h01};
        tvec[1] = '{14'h011, 8'h01, 1'b1, 1'b0, 8'h01, 2'd3, 8'h03};
        tvec[2] = '{14'h013, 8'h03, 1'b1, 1'b0, 8'h03, 2'd3, 8'h07};
        tvec[3] = '{14'h017, 8'h07, 1'b1, 1'b0, 8'h07, 2'd3, 8'h0F};
        tvec[4] = '{14'h01F, 8'h0F, 1'b1, 1'b1, 8'h0F, 2'd2, 8'h1E};
        tvec[5] = '{14'h00E, 8'h1E, 1'b1, 1'b1, 8'h1E, 2'd1, 8'h3C};
        tvec[6] = '{14'h02C, 8'h3C, 1'b0, 1'b0, 8'h3C, 2'd0, 8'h78};
        tvec[7] = '{14'h068, 8'h78, 1'b0, 1'b0, 8'h78, 2'd0, 8'hF0};

        // Reset-state lookups
        do_reset();
        check("reset_count", 32'(dut.count), 0);
        check("reset_pattern", 32'(pattern), 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, lvec[i].pc, lvec[i].tgt, 1'b0, 1'b0, 8'h0);
            check($sformatf("vec%0d_prediction", i), 32'(prediction), 32'(lvec[i].pred));
            check($sformatf("vec%0d_predicted_pc", i), 32'(predicted_pc), 32'(lvec[i].ppc));
            check($sformatf("vec%0d_addr_on_failure", i), 32'(addr_on_failure), 32'(lvec[i].aof));
            check($sformatf("vec%0d_ready", i), 32'(lookup_ready), 1);
        end

        // Two lookups, two non-failing commits of not-taken branches
        do_reset();
        cycle(1'b1, 14'h010, 14'h100, 1'b0, 1'b0, 8'h0);
        check("a_prediction", 32'(prediction), 0);
        check("a_pattern", 32'(pattern), 0);
        check("a_predicted_pc", 32'(predicted_pc), 32'h011);
        check("a_addr_on_failure", 32'(addr_on_failure), 32'h100);
        cycle(1'b1, 14'h010, 14'h100, 1'b0, 1'b0, 8'h0);
        check("a_pattern_after_first", 32'(pattern), 0);
        check("a_count_one", 32'(dut.count), 1);
        cycle(1'b0, 14'h0, 14'h0, 1'b1, 1'b0, 8'h0);
        check("a_count_two", 32'(dut.count), 2);
        cycle(1'b0, 14'h0, 14'h0, 1'b1, 1'b0, 8'h0);
        check("a_ctr_after_one_commit", 32'(dut.ctr_table[8'h10]), 0);
        idle();
        check("a_ctr_floor", 32'(dut.ctr_table[8'h10]), 0);
        check("a_count_drained", 32'(dut.count), 0);

        // Failing commit with a same-cycle lookup that must be dropped
        do_reset();
        cycle(1'b1, 14'h010, 14'h100, 1'b0, 1'b0, 8'h0);
        cycle(1'b1, 14'h020, 14'h300, 1'b1, 1'b1, 8'h00);
        check("b_ready_during_flush", 32'(lookup_ready), 1);
        cycle(1'b0, 14'h011, 14'h200, 1'b0, 1'b0, 8'h0);
        check("b_ctr_trained", 32'(dut.ctr_table[8'h10]), 2);
        check("b_history_restored", 32'(pattern), 32'h01);
        check("b_count_zero", 32'(dut.count), 0);
        check("b_prediction_now_taken", 32'(prediction), 1);
        check("b_predicted_pc_target", 32'(predicted_pc), 32'h200);
        check("b_addr_on_failure_pc1", 32'(addr_on_failure), 32'h012);

        // Saturation in both directions
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tvec[i].pc, 14'h100, 1'b0, 1'b0, 8'h0);
            check($sformatf("sat%0d_pattern", i), 32'(pattern), 32'(tvec[i].pat));
            check($sformatf("sat%0d_prediction", i), 32'(prediction), 32'(tvec[i].pred));
            cycle(1'b0, 14'h0, 14'h0, 1'b1, tvec[i].fail, tvec[i].cpat);
            idle();
            check($sformatf("sat%0d_ctr", i), 32'(dut.ctr_table[8'h10]), 32'(tvec[i].ctr));
            check($sformatf("sat%0d_history", i), 32'(pattern), 32'(tvec[i].hist));
        end

        // Full queue: ready drops, then push and pop together keep count at 4
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(14'h001);
            cycle(1'b1, 14'h000, 14'h100, 1'b0, 1'b0, 8'h0);
            check($sformatf("d_ready_%0d", i), 32'(lookup_ready), 1);
            check($sformatf("d_predicted_pc_%0d", i), 32'(predicted_pc), 32'(exp_q.pop_front()));
        end
        idle();
        check("d_count_full", 32'(dut.count), 4);
        check("d_ready_full", 32'(lookup_ready), 0);
        cycle(1'b1, 14'h000, 14'h100, 1'b1, 1'b0, 8'h0);
        check("d_ready_with_commit", 32'(lookup_ready), 1);
        idle();
        check("d_count_still_full", 32'(dut.count), 4);
        check("d_ctr_idx0", 32'(dut.ctr_table[8'h00]), 0);
        check("d_ready_full_again", 32'(lookup_ready), 0);

        // pc wrap with a taken prediction, then reset mid-stream
        do_reset();
        cycle(1'b1, 14'h3FFE, 14'h100, 1'b0, 1'b0, 8'h0);
        cycle(1'b0, 14'h0, 14'h0, 1'b1, 1'b1, 8'h00);
        cycle(1'b1, 14'h3FFF, 14'h0200, 1'b0, 1'b0, 8'h0);
        check("e_wrap_prediction", 32'(prediction), 1);
        check("e_wrap_predicted_pc", 32'(predicted_pc), 32'h0200);
        check("e_wrap_addr_on_failure", 32'(addr_on_failure), 32'h0000);
        cycle(1'b1, 14'h0040, 14'h0200, 1'b0, 1'b0, 8'h0);
        cycle(1'b1, 14'h0050, 14'h0200, 1'b0, 1'b0, 8'h0);
        idle();
        check("e_count_three", 32'(dut.count), 3);
        @(negedge clk);
        reset = 1'b1;
        lookup_valid = 1'b1; lookup_pc = 14'h0010; lookup_target = 14'h0100;
        commit_valid = 1'b1; commit_failure = 1'b1; commit_pattern = 8'hAA;
        @(negedge clk);
        reset = 1'b0;
        lookup_valid = 1'b0; lookup_pc = 14'h3FFF; lookup_target = 14'h0200;
        commit_valid = 1'b0; commit_failure = 1'b0; commit_pattern = '0;
        #1;
        check("e_reset_count", 32'(dut.count), 0);
        check("e_reset_history", 32'(pattern), 0);
        check("e_reset_prediction", 32'(prediction), 0);
        bad = 0;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            if (dut.ctr_table[i] !== COUNTER_INIT) bad++;
        end
        check("e_reset_table_bad_entries", 32'(bad), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
